// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file constants and arbiter state type
package regfile_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_COUNT  = 32;
    localparam logic [REG_ADDR_W-1:0] ZERO_REG = 5'd0;

    typedef enum logic {
        NORMAL = 1'b0,
        FORCE  = 1'b1
    } arb_state_t;

    // One-hot mask with only the bit for register addr set.
    function automatic logic [REG_COUNT-1:0] reg_bit(input logic [REG_ADDR_W-1:0] addr);
        reg_bit = '0;
        reg_bit[addr] = 1'b1;
    endfunction

endpackage

// File: rtl/regfile_write_arbiter_if.sv
// rtl/regfile_write_arbiter_if.sv - two requester ports plus the register-file write port
interface regfile_write_arbiter_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
);
    logic              p0_valid;
    logic [ADDR_W-1:0] p0_addr;
    logic [DATA_W-1:0] p0_data;
    logic              p0_ready;

    logic              p1_valid;
    logic [ADDR_W-1:0] p1_addr;
    logic [DATA_W-1:0] p1_data;
    logic              p1_ready;

    logic              rf_we;
    logic [ADDR_W-1:0] rf_waddr;
    logic [DATA_W-1:0] rf_wdata;

    // Requester / register-file side.
    modport master (
        output p0_valid, p0_addr, p0_data,
        input  p0_ready,
        output p1_valid, p1_addr, p1_data,
        input  p1_ready,
        input  rf_we, rf_waddr, rf_wdata
    );

    // Arbiter side.
    modport slave (
        input  p0_valid, p0_addr, p0_data,
        output p0_ready,
        input  p1_valid, p1_addr, p1_data,
        output p1_ready,
        output rf_we, rf_waddr, rf_wdata
    );

endinterface

// File: rtl/starve_counter.sv
// rtl/starve_counter.sv - saturating wait counter with clear/inc/hold and terminal flag
module starve_counter #(
    parameter int MAX = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic inc,
    output logic term
);
    localparam int CW = $clog2(MAX + 1);
    localparam logic [CW-1:0] LAST = CW'(MAX - 1);

    logic [CW-1:0] cnt;

    // Count waiting cycles, parking at the terminal value until cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && cnt != LAST) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign term = (cnt == LAST);

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - priority write-port arbiter with starvation guard and pending mask
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int STARVE_MAX = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 enable,
    regfile_write_arbiter_if.slave bus,
    output logic [REG_COUNT-1:0] pend_mask,
    output logic                 p1_forced
);

    arb_state_t        state;
    logic              p0_hs;
    logic              p1_hs;
    logic              accept;
    logic              acc_live;
    logic [ADDR_W-1:0] acc_addr;
    logic [DATA_W-1:0] acc_data;
    logic              starve_clr;
    logic              starve_inc;
    logic              starve_term;
    logic [REG_COUNT-1:0] set_bits;
    logic [REG_COUNT-1:0] clr_bits;

    // Readies: p0 wins in NORMAL, p1 owns the port while FORCE.
    always_comb begin
        bus.p0_ready = enable & (state == NORMAL);
        bus.p1_ready = enable & ((state == FORCE) | ~bus.p0_valid);
    end

    // Winning request; readies are mutually exclusive when both are valid.
    always_comb begin
        p0_hs      = bus.p0_valid & bus.p0_ready;
        p1_hs      = bus.p1_valid & bus.p1_ready;
        accept     = p0_hs | p1_hs;
        acc_addr   = p0_hs ? bus.p0_addr : bus.p1_addr;
        acc_data   = p0_hs ? bus.p0_data : bus.p1_data;
        acc_live   = accept & (acc_addr != ADDR_W'(ZERO_REG));
        starve_clr = enable & (p1_hs | ~bus.p1_valid);
        starve_inc = enable & bus.p1_valid & ~p1_hs & (state == NORMAL);
        set_bits   = acc_live ? reg_bit(REG_ADDR_W'(acc_addr)) : '0;
        clr_bits   = bus.rf_we ? reg_bit(REG_ADDR_W'(bus.rf_waddr)) : '0;
    end

    starve_counter #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (starve_clr),
        .inc   (starve_inc),
        .term  (starve_term)
    );

    // Arbitration state: enter FORCE once p1 has waited long enough, leave on its grant or withdrawal.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= NORMAL;
        end else if (enable) begin
            case (state)
                NORMAL: if (bus.p1_valid & ~bus.p1_ready & starve_term) state <= FORCE;
                FORCE:  if (p1_hs | ~bus.p1_valid) state <= NORMAL;
                default: state <= NORMAL;
            endcase
        end
    end

    // Write pipeline: accepted request drives the register file for exactly one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.rf_we    <= 1'b0;
            bus.rf_waddr <= '0;
            bus.rf_wdata <= '0;
            p1_forced    <= 1'b0;
            pend_mask    <= '0;
        end else begin
            bus.rf_we <= acc_live;
            if (accept) begin
                bus.rf_waddr <= acc_addr;
                bus.rf_wdata <= acc_data;
            end
            p1_forced <= p1_hs & (state == FORCE);
            pend_mask <= (pend_mask & ~clr_bits) | set_bits;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - self-checking bench for regfile_write_arbiter
module tb_regfile_write_arbiter;

    localparam int STARVE = 8;

    logic        clk;
    logic        rst_n;
    logic        enable;
    logic [31:0] pend_mask;
    logic        p1_forced;

    regfile_write_arbiter_if #(.DATA_W(32), .ADDR_W(5)) bus();

    regfile_write_arbiter #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .STARVE_MAX (STARVE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .enable    (enable),
        .bus       (bus),
        .pend_mask (pend_mask),
        .p1_forced (p1_forced)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register file fed by the arbiter's write port.
    logic [31:0] rf_mem [32];
    logic        clr_mem;
    always @(posedge clk) begin
        if (clr_mem) begin
            for (int i = 0; i < 32; i++) rf_mem[i] <= 32'd0;
        end else if (bus.rf_we) begin
            rf_mem[bus.rf_waddr] <= bus.rf_wdata;
        end
    end

    int n_checks;
    int n_fail;

    // Reference model state
    logic [31:0] mem_model [32];
    logic        m_we;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic [31:0] m_pend;
    logic        m_pulse;
    logic        m_force;
    int          waited;

    typedef struct {
        bit        p0v;
        bit [4:0]  p0a;
        bit [31:0] p0d;
        bit        p1v;
        bit [4:0]  p1a;
        bit [31:0] p1d;
        bit        e0;
        bit        e1;
        bit        ewe;
        bit [4:0]  ewa;
        bit [31:0] ewd;
    } vec_t;

    vec_t tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic m_reset();
        m_we    = 1'b0;
        m_waddr = 5'd0;
        m_wdata = 32'd0;
        m_pend  = 32'd0;
        m_pulse = 1'b0;
        m_force = 1'b0;
        waited  = 0;
    endtask

    task automatic set_in(input bit v0, input bit [4:0] a0, input bit [31:0] d0,
                          input bit v1, input bit [4:0] a1, input bit [31:0] d1);
        bus.p0_valid = v0; bus.p0_addr = a0; bus.p0_data = d0;
        bus.p1_valid = v1; bus.p1_addr = a1; bus.p1_data = d1;
    endtask

    // One clock: called at posedge+1 with inputs set; compares at negedge, then advances the model.
    task automatic cycle();
        logic       e0;
        logic       e1;
        logic       h0;
        logic       h1;
        logic [4:0] a;
        @(negedge clk);
        e0 = enable && !m_force;
        e1 = enable && (m_force || !bus.p0_valid);
        chk("p0_ready", 32'(bus.p0_ready), 32'(e0));
        chk("p1_ready", 32'(bus.p1_ready), 32'(e1));
        chk("rf_we", 32'(bus.rf_we), 32'(m_we));
        if (m_we) begin
            chk("rf_waddr", 32'(bus.rf_waddr), 32'(m_waddr));
            chk("rf_wdata", bus.rf_wdata, m_wdata);
        end
        chk("pend_mask", pend_mask, m_pend);
        chk("p1_forced", 32'(p1_forced), 32'(m_pulse));

        h0 = bus.p0_valid && e0;
        h1 = bus.p1_valid && e1;
        if (m_we) begin
            mem_model[m_waddr] = m_wdata;
            m_pend[m_waddr] = 1'b0;
        end
        m_pulse = h1 && m_force;
        m_we = 1'b0;
        if (h0 || h1) begin
            a = h0 ? bus.p0_addr : bus.p1_addr;
            if (a != 5'd0) begin
                m_we    = 1'b1;
                m_waddr = a;
                m_wdata = h0 ? bus.p0_data : bus.p1_data;
                m_pend[a] = 1'b1;
            end
        end
        if (enable) begin
            if (h1 || !bus.p1_valid) begin
                waited  = 0;
                m_force = 1'b0;
            end else if (!m_force) begin
                waited++;
                if (waited >= STARVE) m_force = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc_cycle;
        logic p0r_at;
        logic r0;
        logic r1;

        n_checks = 0;
        n_fail   = 0;
        for (int i = 0; i < 32; i++) mem_model[i] = 32'd0;
        m_reset();

        tbl[0] = '{1, 5'd5,  32'hA5A5A5A5, 1, 5'd6, 32'h00001234, 1, 0, 1, 5'd5,  32'hA5A5A5A5};
        tbl[1] = '{1, 5'd12, 32'hDEADBEEF, 0, 5'd1, 32'h0,        1, 0, 1, 5'd12, 32'hDEADBEEF};
        tbl[2] = '{0, 5'd0,  32'h0,        1, 5'd6, 32'h00001234, 1, 1, 1, 5'd6,  32'h00001234};
        tbl[3] = '{0, 5'd0,  32'h0,        1, 5'd0, 32'hFFFFFFFF, 1, 1, 0, 5'd0,  32'h0};
        tbl[4] = '{1, 5'd0,  32'h00005555, 0, 5'd0, 32'h0,        1, 0, 0, 5'd0,  32'h0};
        tbl[5] = '{0, 5'd0,  32'h0,        0, 5'd0, 32'h0,        1, 1, 0, 5'd0,  32'h0};
        tbl[6] = '{1, 5'd31, 32'hCAFEF00D, 1, 5'd2, 32'h22222222, 1, 0, 1, 5'd31, 32'hCAFEF00D};

        // Reset state
        clr_mem = 1'b1;
        rst_n   = 1'b0;
        enable  = 1'b0;
        set_in(0, 0, 0, 0, 0, 0);
        #1;
        chk("reset_rf_we",     32'(bus.rf_we), 0);
        chk("reset_rf_waddr",  32'(bus.rf_waddr), 0);
        chk("reset_rf_wdata",  bus.rf_wdata, 0);
        chk("reset_pend_mask", pend_mask, 0);
        chk("reset_p1_forced", 32'(p1_forced), 0);
        chk("reset_p0_ready",  32'(bus.p0_ready), 0);
        chk("reset_p1_ready",  32'(bus.p1_ready), 0);
        @(posedge clk);
        @(negedge clk);
        clr_mem = 1'b0;
        rst_n   = 1'b1;
        enable  = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 10; i++) cycle();

        // Table-driven single requests from an idle NORMAL state
        for (int i = 0; i < 7; i++) begin
            set_in(tbl[i].p0v, tbl[i].p0a, tbl[i].p0d, tbl[i].p1v, tbl[i].p1a, tbl[i].p1d);
            #1;
            chk($sformatf("tbl%0d_p0_ready", i), 32'(bus.p0_ready), 32'(tbl[i].e0));
            chk($sformatf("tbl%0d_p1_ready", i), 32'(bus.p1_ready), 32'(tbl[i].e1));
            cycle();
            set_in(0, 0, 0, 0, 0, 0);
            chk($sformatf("tbl%0d_rf_we", i), 32'(bus.rf_we), 32'(tbl[i].ewe));
            if (tbl[i].ewe) begin
                chk($sformatf("tbl%0d_rf_waddr", i), 32'(bus.rf_waddr), 32'(tbl[i].ewa));
                chk($sformatf("tbl%0d_rf_wdata", i), bus.rf_wdata, tbl[i].ewd);
                chk($sformatf("tbl%0d_pend_bit", i), 32'(pend_mask[tbl[i].ewa]), 1);
            end else begin
                chk($sformatf("tbl%0d_pend_zero", i), pend_mask, 0);
            end
            cycle();
        end

        // Starvation: both valid continuously
        cycle();
        acc_cycle = -1;
        p0r_at    = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            set_in(1, 5'd4, $urandom, 1, 5'd8, 32'h0000BEEF);
            #1;
            r0 = bus.p0_ready;
            r1 = bus.p1_ready;
            cycle();
            if (r1) begin
                acc_cycle = k;
                p0r_at    = r0;
                break;
            end
        end
        set_in(0, 0, 0, 0, 0, 0);
        chk("starve_grant_cycle", 32'(acc_cycle), 32'(STARVE + 1));
        chk("starve_p0_ready", 32'(p0r_at), 0);
        chk("starve_forced_pulse", 32'(p1_forced), 1);
        cycle();
        chk("starve_forced_drop", 32'(p1_forced), 0);
        cycle();

        // Enable drop during an rf_we cycle
        set_in(1, 5'd7, 32'h77777777, 0, 0, 0);
        cycle();
        enable = 1'b0;
        set_in(1, 5'd9, 32'h99999999, 1, 5'd10, 32'h10101010);
        #1;
        chk("en0_p0_ready", 32'(bus.p0_ready), 0);
        chk("en0_p1_ready", 32'(bus.p1_ready), 0);
        cycle();
        cycle();
        chk("en0_r7_committed", rf_mem[7], 32'h77777777);
        chk("en0_no_new_we", 32'(bus.rf_we), 0);
        enable = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        cycle();

        // Asynchronous reset mid-stream
        set_in(1, 5'd9, 32'h99999999, 0, 0, 0);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_rf_we", 32'(bus.rf_we), 0);
        chk("arst_pend_mask", pend_mask, 0);
        m_reset();
        #2;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        cycle();
        chk("arst_r9_lost", rf_mem[9], mem_model[9]);

        // Same-address back-to-back writes
        set_in(1, 5'd3, 32'h1, 0, 0, 0);
        cycle();
        set_in(1, 5'd3, 32'h2, 0, 0, 0);
        chk("same_pend3_first", 32'(pend_mask[3]), 1);
        cycle();
        set_in(0, 0, 0, 0, 0, 0);
        chk("same_pend3_second", 32'(pend_mask[3]), 1);
        chk("same_we_second", 32'(bus.rf_we), 1);
        cycle();
        chk("same_pend3_clear", 32'(pend_mask[3]), 0);
        cycle();
        chk("same_r3_final", rf_mem[3], 32'h2);

        // Randomized traffic against the model
        begin
            bit v1;
            v1 = 0;
            for (int n = 0; n < 600; n++) begin
                enable = ($urandom_range(0, 9) != 0);
                if (v1) v1 = ($urandom_range(0, 9) != 0);
                else    v1 = ($urandom_range(0, 2) == 0);
                set_in($urandom_range(0, 2) != 0, 5'($urandom_range(0, 7)), $urandom,
                       v1, 5'($urandom_range(0, 7)), $urandom);
                cycle();
            end
        end
        enable = 1'b1;
        set_in(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) cycle();
        for (int i = 0; i < 32; i++) chk($sformatf("final_r%0d", i), rf_mem[i], mem_model[i]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
